// File: rtl/pll_phase_sweep.sv
// ============================================================================
//  Module   : pll_phase_sweep
//  Purpose  : Sweeps one PLL phase stage over 256 settings, scores each, and
//             applies the best-scoring setting to the cascaded PLL config word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module pll_phase_sweep #(
    parameter logic [7:0]  BASE_ADDR     = 8'hC4,
    parameter logic [23:0] CFG_DEFAULT   = 24'h40047F,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1024,
    parameter logic [15:0] WINDOW_CYCLES = 16'd4096,
    parameter logic [15:0] LOCK_TIMEOUT  = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        locked,
    input  logic        sample_ok,
    input  logic [7:0]  Address,
    input  logic [31:0] DataIn,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] DataOut,
    output logic [23:0] cfg,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SET, ST_SETTLE, ST_LOCKWAIT,
        ST_MEASURE, ST_COMPARE, ST_APPLY, ST_FAIL
    } state_t;

    state_t      state, state_n;
    logic [23:0] cfg_n;
    logic        done_n, err, err_n;
    logic [15:0] best_score, best_score_n, score, score_n, counter, counter_n;
    logic [7:0]  best_set, best_set_n, step, step_n, saved, saved_n;
    logic [1:0]  stage, stage_n;

    logic wr_ctrl, wr_cfg, start, abort;
    logic unused_data;

    assign wr_ctrl     = Write && (Address == BASE_ADDR);
    assign wr_cfg      = Write && (Address == BASE_ADDR + 8'd2);
    assign start       = wr_ctrl && DataIn[0];
    assign abort       = wr_ctrl && DataIn[3];
    assign busy        = (state != ST_IDLE);
    assign unused_data = ^DataIn[31:24];

    function automatic logic [7:0] get_byte(input logic [23:0] w, input logic [1:0] s);
        case (s)
            2'd1:    get_byte = w[15:8];
            2'd2:    get_byte = w[23:16];
            default: get_byte = w[7:0];
        endcase
    endfunction

    function automatic logic [23:0] put_byte(input logic [23:0] w, input logic [1:0] s,
                                             input logic [7:0] b);
        put_byte = w;
        case (s)
            2'd1:    put_byte[15:8]  = b;
            2'd2:    put_byte[23:16] = b;
            default: put_byte[7:0]   = b;
        endcase
    endfunction

    always_comb begin
        state_n      = state;
        cfg_n        = cfg;
        done_n       = done;
        err_n        = err;
        best_score_n = best_score;
        best_set_n   = best_set;
        score_n      = score;
        counter_n    = counter;
        step_n       = step;
        saved_n      = saved;
        stage_n      = stage;

        case (state)
            ST_IDLE: begin
                if (wr_cfg)
                    cfg_n = DataIn[23:0];
                if (start && !abort) begin
                    if (DataIn[2:1] == 2'd3) begin
                        err_n  = 1'b1;
                        done_n = 1'b0;
                    end else begin
                        stage_n      = DataIn[2:1];
                        saved_n      = get_byte(cfg, DataIn[2:1]);
                        best_score_n = '0;
                        best_set_n   = '0;
                        err_n        = 1'b0;
                        done_n       = 1'b0;
                        step_n       = '0;
                        state_n      = ST_SET;
                    end
                end
            end
            ST_SET: begin
                cfg_n     = put_byte(cfg, stage, step);
                counter_n = SETTLE_CYCLES;
                state_n   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (counter <= 16'd1) begin
                    counter_n = LOCK_TIMEOUT;
                    state_n   = ST_LOCKWAIT;
                end else begin
                    counter_n = counter - 16'd1;
                end
            end
            ST_LOCKWAIT: begin
                if (locked) begin
                    counter_n = WINDOW_CYCLES;
                    score_n   = '0;
                    state_n   = ST_MEASURE;
                end else if (counter <= 16'd1) begin
                    state_n = ST_FAIL;
                end else begin
                    counter_n = counter - 16'd1;
                end
            end
            ST_MEASURE: begin
                // Lock loss invalidates the partial window; restart from scratch.
                if (!locked) begin
                    counter_n = LOCK_TIMEOUT;
                    score_n   = '0;
                    state_n   = ST_LOCKWAIT;
                end else begin
                    if (score != 16'hFFFF)
                        score_n = score + {15'd0, sample_ok};
                    if (counter <= 16'd1)
                        state_n = ST_COMPARE;
                    else
                        counter_n = counter - 16'd1;
                end
            end
            ST_COMPARE: begin
                if (score > best_score) begin
                    best_score_n = score;
                    best_set_n   = step;
                end
                if (step == 8'hFF) begin
                    state_n = ST_APPLY;
                end else begin
                    step_n  = step + 8'd1;
                    state_n = ST_SET;
                end
            end
            ST_APPLY: begin
                cfg_n   = put_byte(cfg, stage, best_set);
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            ST_FAIL: begin
                cfg_n   = put_byte(cfg, stage, saved);
                err_n   = 1'b1;
                done_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (abort && state != ST_IDLE) begin
            cfg_n   = put_byte(cfg, stage, saved);
            done_n  = 1'b0;
            err_n   = 1'b0;
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cfg        <= CFG_DEFAULT;
            done       <= 1'b0;
            err        <= 1'b0;
            best_score <= '0;
            best_set   <= '0;
            score      <= '0;
            counter    <= '0;
            step       <= '0;
            saved      <= '0;
            stage      <= '0;
        end else begin
            state      <= state_n;
            cfg        <= cfg_n;
            done       <= done_n;
            err        <= err_n;
            best_score <= best_score_n;
            best_set   <= best_set_n;
            score      <= score_n;
            counter    <= counter_n;
            step       <= step_n;
            saved      <= saved_n;
            stage      <= stage_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DataOut <= '0;
        end else if (Read && Address == BASE_ADDR + 8'd1) begin
            DataOut <= {best_score, best_set, 5'b0, err, done, busy};
        end else if (Read && Address == BASE_ADDR + 8'd2) begin
            DataOut <= {8'd0, cfg};
        end else begin
            DataOut <= '0;
        end
    end

endmodule

`default_nettype wire
